// File: rtl/riscv_pkg.sv
// Shared RV64I+Zba decode definitions.
// Provides the immediate classes, the major-opcode constants, the decoded-entry
// record handed from decode to EX, and two small opcode classification helpers.
package riscv_pkg;

  localparam int DEC_XLEN = 64;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef struct packed {
    logic [DEC_XLEN-1:0] pc;
    logic [DEC_XLEN-1:0] imm;
    imm_type_t           imm_type;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                illegal;
  } dec_entry_t;

  // Immediate class for each major opcode; unsupported opcodes carry no immediate.
  function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: return IMM_I;
      OPC_STORE:                                     return IMM_S;
      OPC_BRANCH:                                    return IMM_B;
      OPC_LUI, OPC_AUIPC:                            return IMM_U;
      OPC_JAL:                                       return IMM_J;
      default:                                       return IMM_NONE;
    endcase
  endfunction

  // Zba shares the OP/OP_32 major opcodes, so it needs no extra entry here.
  function automatic logic opcode_legal(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32,
      OPC_STORE, OPC_OP, OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR,
      OPC_JAL, OPC_SYSTEM: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry FIFO skid buffer between decode and EX.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   flush      empties the buffer on the next edge; beats push and pop
//   push       write request, honoured only while ready
//   push_data  entry to write
//   pop        read request, honoured only while an entry is held
//   head       oldest entry
//   count      number of held entries, 0..2
//   ready      registered "not full"
module decode_skid_buf #(
  parameter type entry_t = logic [7:0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count,
  output logic       ready
);

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push_ok;
  logic       pop_ok;
  logic [1:0] count_next;

  assign push_ok = push && ready && !flush;
  assign pop_ok  = pop && (count != 2'd0) && !flush;
  assign head    = mem[rd_ptr];

  // Occupancy after this edge. A simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 2'd0;
    end else if (push_ok && !pop_ok) begin
      count_next = count + 2'd1;
    end else if (pop_ok && !push_ok) begin
      count_next = count - 2'd1;
    end
  end

  // Storage and pointers. A flush moves the write pointer onto the read
  // pointer rather than clearing both. That keeps the head entry, and so
  // the visible ex_* data, unchanged. ready comes from count_next so that it
  // is a plain flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      ready  <= 1'b1;
    end else begin
      count <= count_next;
      ready <= (count_next != 2'd2);
      if (flush) begin
        wr_ptr <= rd_ptr;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop_ok) begin
          rd_ptr <= ~rd_ptr;
        end
      end
    end
  end

endmodule

// File: rtl/immediate_gen.sv
// Immediate generator: assembles the sign-extended 64-bit immediate for the
// selected immediate class.
// Ports:
//   instr    in  [31:7]  instruction bits above the opcode field
//   imm_type in          immediate class chosen by the opcode decoder
//   imm      out [63:0]  sign-extended immediate, zero for IMM_NONE
module immediate_gen
  import riscv_pkg::*;
(
  input  logic [31:7]         instr,
  input  imm_type_t           imm_type,
  output logic [DEC_XLEN-1:0] imm
);

  // Every format takes its sign from instr[31]; B and J immediates are
  // half-word aligned, so their bit 0 is always zero.
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {{32{instr[31]}}, instr[31:12], 12'h000};
      IMM_J: imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller for the RV64I+Zba core.
// It decodes the fetched instruction combinationally and buffers the result
// in a 2-entry skid buffer toward EX. It also handles load-use stall, flush
// and illegal-opcode flagging.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_valid/if_ready              fetch handshake; if_ready is registered
//   if_instr, if_pc                fetched instruction word and its address
//   flush                          drop buffered and incoming instructions
//   ex_load_valid, ex_load_rd      outstanding load in EX and its destination
//   ex_valid/ex_ready              EX handshake for the head entry
//   ex_pc, ex_imm, ex_imm_type     head address, immediate and immediate class
//   ex_opcode, ex_funct3, ex_funct7 raw instruction fields of the head
//   ex_rs1, ex_rs2, ex_rd          register fields, zero where the format lacks them
//   ex_illegal                     head opcode is outside the supported set
// Only XLEN = 64 is supported; the decoded-entry record is fixed at 64 bits.
module decode_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rd,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output imm_type_t       ex_imm_type,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal
);

  logic [6:0]          opcode;
  imm_type_t           dec_imm_type;
  logic                dec_legal;
  logic                has_rs1;
  logic                has_rs2;
  logic                has_rd;
  logic [DEC_XLEN-1:0] dec_imm;
  dec_entry_t          dec_entry;
  dec_entry_t          head;
  logic [1:0]          count;
  logic                stall;
  logic                pop;

  assign opcode = if_instr[6:0];

  // Register-field presence per format. An illegal opcode keeps no register
  // fields at all, so it can never create a false load-use stall.
  always_comb begin
    dec_imm_type = imm_type_of(opcode);
    dec_legal    = opcode_legal(opcode);
    has_rs1      = 1'b0;
    has_rs2      = 1'b0;
    has_rd       = 1'b0;
    if (dec_legal) begin
      has_rs1 = 1'b1;
      has_rd  = 1'b1;
      case (opcode)
        OPC_OP, OPC_OP_32: has_rs2 = 1'b1;
        OPC_STORE, OPC_BRANCH: begin
          has_rs2 = 1'b1;
          has_rd  = 1'b0;
        end
        OPC_LUI, OPC_AUIPC, OPC_JAL: has_rs1 = 1'b0;
        default: has_rs1 = 1'b1;
      endcase
    end
  end

  immediate_gen u_immediate_gen (
    .instr    (if_instr[31:7]),
    .imm_type (dec_imm_type),
    .imm      (dec_imm)
  );

  // Assemble the entry written on accept. An illegal opcode already maps to
  // IMM_NONE, so its immediate is zero without extra masking.
  always_comb begin
    dec_entry          = '0;
    dec_entry.pc       = if_pc;
    dec_entry.imm      = dec_imm;
    dec_entry.imm_type = dec_imm_type;
    dec_entry.opcode   = opcode;
    dec_entry.funct3   = if_instr[14:12];
    dec_entry.funct7   = if_instr[31:25];
    dec_entry.rs1      = has_rs1 ? if_instr[19:15] : 5'd0;
    dec_entry.rs2      = has_rs2 ? if_instr[24:20] : 5'd0;
    dec_entry.rd       = has_rd  ? if_instr[11:7]  : 5'd0;
    dec_entry.illegal  = !dec_legal;
  end

  decode_skid_buf #(
    .entry_t (dec_entry_t)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (if_valid),
    .push_data (dec_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .ready     (if_ready)
  );

  // Load-use hazard on the head entry. x0 never stalls, and the masked
  // register fields are compared, so unused encoding bits cannot stall.
  assign stall    = ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((ex_load_rd == head.rs1) || (ex_load_rd == head.rs2));
  assign ex_valid = (count != 2'd0) && !stall;
  assign pop      = ex_valid && ex_ready;

  assign ex_pc       = head.pc;
  assign ex_imm      = head.imm;
  assign ex_imm_type = head.imm_type;
  assign ex_opcode   = head.opcode;
  assign ex_funct3   = head.funct3;
  assign ex_funct7   = head.funct7;
  assign ex_rs1      = head.rs1;
  assign ex_rs2      = head.rs2;
  assign ex_rd       = head.rd;
  assign ex_illegal  = head.illegal;

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl.
// Expected decoded entries are queued when an instruction is accepted. A
// monitor pops and compares them on every EX handshake.
module tb_decode_ctrl;
  import riscv_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    imm_type_t   it;
    logic [6:0]  opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic [63:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        ex_load_valid = 1'b0;
  logic [4:0]  ex_load_rd = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [63:0] ex_pc;
  logic [63:0] ex_imm;
  imm_type_t   ex_imm_type;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_illegal;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  decode_ctrl #(.XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .flush         (flush),
    .ex_load_valid (ex_load_valid),
    .ex_load_rd    (ex_load_rd),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_imm_type   (ex_imm_type),
    .ex_opcode     (ex_opcode),
    .ex_funct3     (ex_funct3),
    .ex_funct7     (ex_funct7),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_illegal    (ex_illegal)
  );

  // 10 ns clock period
  always #5 clk = ~clk;

  // Scoreboard monitor: a handshake seen at the falling edge completes on the
  // next rising edge, so the head entry is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && !flush && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_output got pc=%h want no output", ex_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (ex_pc !== e.pc) begin
          n_fail++;
          $display("[TB] FAIL pc got %h want %h", ex_pc, e.pc);
        end
        n_checks++;
        if (ex_imm !== e.imm) begin
          n_fail++;
          $display("[TB] FAIL imm(pc=%h) got %h want %h", e.pc, ex_imm, e.imm);
        end
        n_checks++;
        if (ex_imm_type !== e.it) begin
          n_fail++;
          $display("[TB] FAIL imm_type(pc=%h) got %0d want %0d", e.pc, ex_imm_type, e.it);
        end
        n_checks++;
        if (ex_opcode !== e.opc) begin
          n_fail++;
          $display("[TB] FAIL opcode(pc=%h) got %h want %h", e.pc, ex_opcode, e.opc);
        end
        n_checks++;
        if ({ex_rs1, ex_rs2, ex_rd} !== {e.rs1, e.rs2, e.rd}) begin
          n_fail++;
          $display("[TB] FAIL regs(pc=%h) got rs1=%0d rs2=%0d rd=%0d want rs1=%0d rs2=%0d rd=%0d",
                   e.pc, ex_rs1, ex_rs2, ex_rd, e.rs1, e.rs2, e.rd);
        end
        n_checks++;
        if (ex_illegal !== e.ill) begin
          n_fail++;
          $display("[TB] FAIL illegal(pc=%h) got %b want %b", e.pc, ex_illegal, e.ill);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [63:0] pc, input logic [63:0] imm, input imm_type_t it,
                              input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic ill);
    exp_t e;
    e.pc = pc; e.imm = imm; e.it = it; e.opc = opc;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ill = ill;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  // Drive one instruction for one edge; caller guarantees if_ready is high.
  task automatic send_one(input logic [31:0] ins, input exp_t e);
    applyStimulus(1'b1, ins, e.pc);
    exp_q.push_back(e);
    tick();
    applyStimulus(1'b0, 32'h0, 64'h0);
  endtask

  // Wait (bounded) for all expectations to be consumed, then let the last pop complete.
  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (if_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_if_ready got %b want 1", if_ready); end
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ex_valid got %b want 0", ex_valid); end
    n_checks++;
    if ({ex_pc, ex_imm} !== 128'h0) begin n_fail++; $display("[TB] FAIL reset_data got pc=%h imm=%h want 0", ex_pc, ex_imm); end
    n_checks++;
    if (ex_imm_type !== IMM_NONE) begin n_fail++; $display("[TB] FAIL reset_imm_type got %0d want 0", ex_imm_type); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_imm_types();
    logic [31:0] ins_tab [8];
    exp_t        exp_tab [8];
    ins_tab[0] = 32'hFFF00093; exp_tab[0] = mk(64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 7'h13, 5'd0, 5'd0, 5'd1, 1'b0);
    ins_tab[1] = 32'h00112223; exp_tab[1] = mk(64'h1004, 64'h4, IMM_S, 7'h23, 5'd2, 5'd1, 5'd0, 1'b0);
    ins_tab[2] = 32'hFE000EE3; exp_tab[2] = mk(64'h1008, 64'hFFFF_FFFF_FFFF_FFFC, IMM_B, 7'h63, 5'd0, 5'd0, 5'd0, 1'b0);
    ins_tab[3] = 32'h800002B7; exp_tab[3] = mk(64'h100C, 64'hFFFF_FFFF_8000_0000, IMM_U, 7'h37, 5'd0, 5'd0, 5'd5, 1'b0);
    ins_tab[4] = 32'h008000EF; exp_tab[4] = mk(64'h1010, 64'h8, IMM_J, 7'h6F, 5'd0, 5'd0, 5'd1, 1'b0);
    ins_tab[5] = 32'h2062A233; exp_tab[5] = mk(64'h1014, 64'h0, IMM_NONE, 7'h33, 5'd5, 5'd6, 5'd4, 1'b0);
    ins_tab[6] = 32'h0000007F; exp_tab[6] = mk(64'h1018, 64'h0, IMM_NONE, 7'h7F, 5'd0, 5'd0, 5'd0, 1'b1);
    ins_tab[7] = 32'hFF813383; exp_tab[7] = mk(64'h101C, 64'hFFFF_FFFF_FFFF_FFF8, IMM_I, 7'h03, 5'd2, 5'd0, 5'd7, 1'b0);
    ex_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_one(ins_tab[i], exp_tab[i]);
      wait_drain(10);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins_tab [3];
    exp_t        exp_tab [3];
    logic        rdy_exp [6];
    int          idx;
    logic        acc;
    ins_tab[0] = 32'hFFF00093; exp_tab[0] = mk(64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 7'h13, 5'd0, 5'd0, 5'd1, 1'b0);
    ins_tab[1] = 32'h00112223; exp_tab[1] = mk(64'h2004, 64'h4, IMM_S, 7'h23, 5'd2, 5'd1, 5'd0, 1'b0);
    ins_tab[2] = 32'h002081B3; exp_tab[2] = mk(64'h2008, 64'h0, IMM_NONE, 7'h33, 5'd1, 5'd2, 5'd3, 1'b0);
    rdy_exp[0] = 1'b1; rdy_exp[1] = 1'b1; rdy_exp[2] = 1'b0;
    rdy_exp[3] = 1'b0; rdy_exp[4] = 1'b0; rdy_exp[5] = 1'b1;
    idx = 0;
    ex_ready = 1'b0;
    applyStimulus(1'b1, ins_tab[0], exp_tab[0].pc);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (if_ready !== rdy_exp[cyc]) begin
        n_fail++;
        $display("[TB] FAIL b2b_if_ready(cycle %0d) got %b want %b", cyc, if_ready, rdy_exp[cyc]);
      end
      acc = 1'b0;
      if (if_valid && if_ready) begin
        exp_q.push_back(exp_tab[idx]);
        acc = 1'b1;
      end
      if (cyc == 2 || cyc == 3) begin
        n_checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 64'h2000) begin
          n_fail++;
          $display("[TB] FAIL b2b_hold(cycle %0d) got valid=%b pc=%h want valid=1 pc=2000", cyc, ex_valid, ex_pc);
        end
      end
      tick();
      if (acc) idx++;
      if (idx >= 3) applyStimulus(1'b0, 32'h0, 64'h0);
      else          applyStimulus(1'b1, ins_tab[idx], exp_tab[idx].pc);
      if (cyc == 3) ex_ready = 1'b1;
    end
    n_checks++;
    if (idx != 3) begin n_fail++; $display("[TB] FAIL b2b_accepts got %0d want 3", idx); end
    applyStimulus(1'b0, 32'h0, 64'h0);
    wait_drain(10);
  endtask

  task automatic test_hazard();
    ex_ready = 1'b1;
    ex_load_valid = 1'b1;
    ex_load_rd = 5'd1;
    send_one(32'h002081B3, mk(64'h3000, 64'h0, IMM_NONE, 7'h33, 5'd1, 5'd2, 5'd3, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_rs1 got %b want 0", ex_valid); end
    end
    tick();
    ex_load_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_release got %b want 1", ex_valid); end
    wait_drain(10);

    ex_load_valid = 1'b1;
    ex_load_rd = 5'd2;
    send_one(32'h002081B3, mk(64'h3004, 64'h0, IMM_NONE, 7'h33, 5'd1, 5'd2, 5'd3, 1'b0));
    @(negedge clk);
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_rs2 got %b want 0", ex_valid); end
    tick();
    ex_load_valid = 1'b0;
    wait_drain(10);

    ex_load_valid = 1'b1;
    ex_load_rd = 5'd0;
    send_one(32'h000001B3, mk(64'h3008, 64'h0, IMM_NONE, 7'h33, 5'd0, 5'd0, 5'd3, 1'b0));
    @(negedge clk);
    n_checks++;
    if (ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL no_stall_x0 got %b want 1", ex_valid); end
    wait_drain(10);

    ex_load_rd = 5'd31;
    send_one(32'hFFF00093, mk(64'h300C, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 7'h13, 5'd0, 5'd0, 5'd1, 1'b0));
    @(negedge clk);
    n_checks++;
    if (ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL no_stall_masked_rs2 got %b want 1", ex_valid); end
    wait_drain(10);
    ex_load_valid = 1'b0;
    ex_load_rd = 5'd0;
  endtask

  task automatic test_flush();
    ex_ready = 1'b0;
    send_one(32'hFFF00093, mk(64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 7'h13, 5'd0, 5'd0, 5'd1, 1'b0));
    send_one(32'h00112223, mk(64'h4004, 64'h4, IMM_S, 7'h23, 5'd2, 5'd1, 5'd0, 1'b0));
    applyStimulus(1'b1, 32'h00500313, 64'h4008);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 64'h0);
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_full_valid got %b want 0", ex_valid); end
    n_checks++;
    if (if_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_full_ready got %b want 1", if_ready); end

    send_one(32'h000001B3, mk(64'h4010, 64'h0, IMM_NONE, 7'h33, 5'd0, 5'd0, 5'd3, 1'b0));
    applyStimulus(1'b1, 32'h00500313, 64'h4014);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 64'h0);
    exp_q.delete();
    ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_drops_accept got %b want 0", ex_valid); end
    end
    n_checks++;
    if (ex_pc !== 64'h4010) begin n_fail++; $display("[TB] FAIL flush_hold_pc got %h want 4010", ex_pc); end
    tick();
    send_one(32'h002081B3, mk(64'h4020, 64'h0, IMM_NONE, 7'h33, 5'd1, 5'd2, 5'd3, 1'b0));
    wait_drain(10);
  endtask

  task automatic test_reset_midstream();
    ex_ready = 1'b0;
    send_one(32'hFFF00093, mk(64'h5000, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 7'h13, 5'd0, 5'd0, 5'd1, 1'b0));
    send_one(32'h00112223, mk(64'h5004, 64'h4, IMM_S, 7'h23, 5'd2, 5'd1, 5'd0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_valid got %b want 0", ex_valid); end
    n_checks++;
    if (if_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_ready got %b want 1", if_ready); end
    n_checks++;
    if (ex_pc !== 64'h0) begin n_fail++; $display("[TB] FAIL rst_mid_pc got %h want 0", ex_pc); end
    tick();
    rst = 1'b0;
    ex_ready = 1'b1;
    tick();
    send_one(32'h800002B7, mk(64'h5008, 64'hFFFF_FFFF_8000_0000, IMM_U, 7'h37, 5'd0, 5'd0, 5'd5, 1'b0));
    wait_drain(10);
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    test_reset();
    test_imm_types();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
